// File: rtl/instr_fetch_unit_if.sv
// Handshake bundle for the fetch unit: memory request/response and core-side instruction/redirect signals.
// master = fetch unit side, slave = memory/core side.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Decoupled instruction fetch: credit-limited requests to a variable-latency memory, in-order prefetch
// queue of {word, pc}, and redirect handling that flushes the queue and drops stale in-flight responses.
module instr_fetch_unit #(
    parameter int unsigned DEPTH           = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned        PTR_W     = $clog2(DEPTH);
    localparam int unsigned        CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0]     DEPTH_C   = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]   MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_resp_pc;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [31:0]      r_data [DEPTH];
    logic [31:0]      r_pc   [DEPTH];

    logic [CNT_W:0]   w_inflight;
    logic [CNT_W-1:0] w_out_next;
    logic [31:0]      w_redirect_pc;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_rsp_drop;
    logic             w_push;
    logic             w_pop;
    logic             w_head_valid;

    // Queued entries plus in-flight requests may never exceed the queue size, so a push never meets a full queue.
    assign w_inflight    = {1'b0, r_occ} + {1'b0, r_outstanding};
    assign w_req_valid   = !reset && !bus.redirect && (w_inflight < DEPTH_C)
                           && (r_outstanding < MAX_OUT_C) && (r_drop_cnt == '0);
    assign w_req_fire    = w_req_valid && bus.imem_req_ready;
    assign w_rsp_drop    = bus.imem_rsp_valid && (r_drop_cnt != '0);
    assign w_push        = bus.imem_rsp_valid && (r_drop_cnt == '0) && !bus.redirect;
    assign w_head_valid  = !reset && (r_occ != '0);
    assign w_pop         = w_head_valid && bus.instr_ready && !bus.redirect;
    assign w_out_next    = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(bus.imem_rsp_valid);
    assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = reset ? RESET_PC : r_fetch_pc;
    assign bus.instr_valid    = w_head_valid;
    assign bus.instr          = reset ? '0 : r_data[r_rd_ptr];
    assign bus.instr_pc       = reset ? '0 : r_pc[r_rd_ptr];

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_occ         <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (bus.redirect) begin
            // Everything still in flight is stale; a response landing this cycle is already counted out.
            r_fetch_pc    <= w_redirect_pc;
            r_resp_pc     <= w_redirect_pc;
            r_rd_ptr      <= r_wr_ptr;
            r_occ         <= '0;
            r_outstanding <= w_out_next;
            r_drop_cnt    <= w_out_next;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outstanding <= w_out_next;
            if (w_rsp_drop) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // NOTE: the queue storage is reset on purpose: the head is shown even when empty and must never be X.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_data[r_wr_ptr] <= bus.imem_rsp_data;
            r_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: an in-order variable-latency memory model feeds the main instance,
// and a second instance with a high RESET_PC is driven by hand to exercise address wrap and mid-stream reset.
module tb_instr_fetch_unit;
    logic clk;
    logic reset;
    logic reset2;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if bus2 ();

    instr_fetch_unit #(
        .DEPTH(4), .RESET_PC(32'h0000_0000), .MAX_OUTSTANDING(4)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );

    instr_fetch_unit #(
        .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .MAX_OUTSTANDING(4)
    ) u_dut_hi (
        .clk(clk), .reset(reset2), .bus(bus2.master)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mem_req_t;

    mem_req_t    mq[$];
    logic [31:0] fire_q[$];
    int unsigned cyc = 0;
    int unsigned mem_lat = 1;
    int          n_checks = 0;
    int          n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: records accepted requests and retires the head response when the DUT samples it.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            mq.delete();
        end else begin
            if (bus.imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{addr: bus.imem_req_addr, due: cyc + mem_lat});
                fire_q.push_back(bus.imem_req_addr);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = ~mq[0].addr;
        end else begin
            bus.imem_rsp_valid = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int k;
        logic [31:0] e;

        reset  = 1'b1;
        reset2 = 1'b1;
        bus.imem_req_ready  = 1'b1;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = '0;
        bus.instr_ready     = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_pc     = '0;
        bus2.imem_req_ready = 1'b1;
        bus2.imem_rsp_valid = 1'b0;
        bus2.imem_rsp_data  = '0;
        bus2.instr_ready    = 1'b0;
        bus2.redirect       = 1'b0;
        bus2.redirect_pc    = '0;

        // Outputs while reset is held
        tick();
        tick();
        #1;
        check("rst_req_valid",   32'(bus.imem_req_valid), 32'd0);
        check("rst_req_addr",    bus.imem_req_addr,       32'h0000_0000);
        check("rst_instr_valid", 32'(bus.instr_valid),    32'd0);
        check("rst_instr",       bus.instr,               32'd0);
        check("rst_instr_pc",    bus.instr_pc,            32'd0);

        // 1: one-cycle memory, core always ready -> one instruction per cycle after a two-cycle fill
        tick();
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        check("t1_c0_req_valid",   32'(bus.imem_req_valid), 32'd1);
        check("t1_c0_addr",        bus.imem_req_addr,       32'h0000_0000);
        check("t1_c0_instr_valid", 32'(bus.instr_valid),    32'd0);
        check("t1_c0_instr_pc",    bus.instr_pc,            32'd0);
        tick();
        #1;
        check("t1_c1_addr",        bus.imem_req_addr,       32'h0000_0004);
        check("t1_c1_instr_valid", 32'(bus.instr_valid),    32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            check("t1_instr_valid", 32'(bus.instr_valid), 32'd1);
            check("t1_instr_pc",    bus.instr_pc,         32'(4 * i));
            check("t1_instr",       bus.instr,            ~(32'(4 * i)));
            check("t1_req_addr",    bus.imem_req_addr,    32'(8 + 4 * i));
        end

        // 2: core stalled -> exactly four requests, then drain in order with no bubble
        mem_lat = 1;
        bus.instr_ready = 1'b0;
        do_reset();
        base = fire_q.size();
        repeat (20) tick();
        #1;
        check("t2_req_count",   32'(fire_q.size() - base), 32'd4);
        check("t2_addr0",       fire_q[base + 0],          32'h0000_0000);
        check("t2_addr1",       fire_q[base + 1],          32'h0000_0004);
        check("t2_addr2",       fire_q[base + 2],          32'h0000_0008);
        check("t2_addr3",       fire_q[base + 3],          32'h0000_000C);
        check("t2_req_valid",   32'(bus.imem_req_valid),   32'd0);
        check("t2_instr_valid", 32'(bus.instr_valid),      32'd1);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                #1;
            end
            check("t2_drain_valid", 32'(bus.instr_valid), 32'd1);
            check("t2_drain_pc",    bus.instr_pc,         32'(4 * i));
        end

        // 5: memory not ready -> request held with stable address, PC advances only on acceptance
        mem_lat = 1;
        bus.instr_ready = 1'b0;
        do_reset();
        bus.imem_req_ready = 1'b0;
        base = fire_q.size();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_hold_valid", 32'(bus.imem_req_valid), 32'd1);
            check("t5_hold_addr",  bus.imem_req_addr,       32'h0000_0000);
            tick();
        end
        bus.imem_req_ready = 1'b1;
        #1;
        check("t5_no_accept", 32'(fire_q.size() - base), 32'd0);
        tick();
        #1;
        check("t5_accept_cnt",  32'(fire_q.size() - base), 32'd1);
        check("t5_accept_addr", fire_q[base],              32'h0000_0000);
        check("t5_next_addr",   bus.imem_req_addr,         32'h0000_0004);

        // 3: three requests in flight, redirect to an unaligned target -> three drops, resume at 0x100
        mem_lat = 4;
        bus.instr_ready = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0102;
        #1;
        check("t3_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick();
        bus.redirect = 1'b0;
        #1;
        check("t3_flush_instr_valid", 32'(bus.instr_valid),    32'd0);
        check("t3_drop1_req_valid",   32'(bus.imem_req_valid), 32'd0);
        tick();
        #1;
        check("t3_drop2_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick();
        #1;
        check("t3_drop3_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick();
        #1;
        check("t3_resume_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t3_resume_addr",      bus.imem_req_addr,       32'h0000_0100);
        check("t3_resume_empty",     32'(bus.instr_valid),    32'd0);
        k = 0;
        while (!bus.instr_valid && k < 10) begin
            tick();
            #1;
            k++;
        end
        check("t3_wait_cycles", 32'(k),       32'd5);
        check("t3_instr_pc",    bus.instr_pc, 32'h0000_0100);
        check("t3_instr",       bus.instr,    32'hFFFF_FEFF);

        // 4: redirect together with a response and a pop -> response dropped, pop ignored
        mem_lat = 3;
        bus.instr_ready = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        tick();
        #1;
        check("t4_head_valid", 32'(bus.instr_valid),    32'd1);
        check("t4_head_pc",    bus.instr_pc,            32'h0000_0000);
        check("t4_req_valid",  32'(bus.imem_req_valid), 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0203;
        tick();
        bus.redirect = 1'b0;
        #1;
        check("t4_flush_instr_valid", 32'(bus.instr_valid),    32'd0);
        check("t4_drop1_req_valid",   32'(bus.imem_req_valid), 32'd0);
        tick();
        #1;
        check("t4_drop2_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("t4_drop2_empty",     32'(bus.instr_valid),    32'd0);
        tick();
        #1;
        check("t4_resume_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t4_resume_addr",      bus.imem_req_addr,       32'h0000_0200);
        k = 0;
        while (!bus.instr_valid && k < 10) begin
            tick();
            #1;
            k++;
        end
        check("t4_wait_cycles", 32'(k),       32'd4);
        check("t4_instr_pc",    bus.instr_pc, 32'h0000_0200);
        check("t4_instr",       bus.instr,    32'hFFFF_FDFF);

        // 6: high reset PC wraps through zero; reset mid-stream clears the head and restores the address
        tick();
        reset2 = 1'b0;
        #1;
        check("t6_c0_req_valid", 32'(bus2.imem_req_valid), 32'd1);
        check("t6_c0_addr",      bus2.imem_req_addr,       32'hFFFF_FFF8);
        for (int j = 0; j < 4; j++) begin
            tick();
            bus2.imem_rsp_valid = 1'b1;
            bus2.imem_rsp_data  = ~(32'hFFFF_FFF8 + 32'(4 * j));
            #1;
            if (j < 3) begin
                check("t6_req_addr", bus2.imem_req_addr, 32'hFFFF_FFFC + 32'(4 * j));
            end else begin
                check("t6_credit_stop", 32'(bus2.imem_req_valid), 32'd0);
            end
        end
        tick();
        bus2.imem_rsp_valid = 1'b0;
        bus2.instr_ready    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick();
            end
            #1;
            e = 32'hFFFF_FFF8 + 32'(4 * i);
            check("t6_instr_valid", 32'(bus2.instr_valid), 32'd1);
            check("t6_instr_pc",    bus2.instr_pc,         e);
            check("t6_instr",       bus2.instr,            ~e);
        end
        tick();
        reset2 = 1'b1;
        #1;
        check("t6_inrst_instr_valid", 32'(bus2.instr_valid),    32'd0);
        check("t6_inrst_req_valid",   32'(bus2.imem_req_valid), 32'd0);
        check("t6_inrst_addr",        bus2.imem_req_addr,       32'hFFFF_FFF8);
        check("t6_inrst_instr",       bus2.instr,               32'd0);
        tick();
        reset2 = 1'b0;
        #1;
        check("t6_post_instr_valid", 32'(bus2.instr_valid), 32'd0);
        check("t6_post_addr",        bus2.imem_req_addr,    32'hFFFF_FFF8);
        check("t6_post_instr_pc",    bus2.instr_pc,         32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
